// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// Define FIFO_ARB_LOCK_EN to let an owner keep the port for up to BURST words.
module fifo_wr_arbiter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned BURST = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*WIDTH-1:0]     data,
   output logic [NREQ-1:0]           gnt,
   output logic                      fifo_wr,
   output logic [WIDTH-1:0]          fifo_data,
   input  logic                      fifo_full,
   output logic [$clog2(NREQ)-1:0]   owner,
   output logic                      busy
);

   localparam int unsigned LW = $clog2(NREQ);

`ifdef FIFO_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif
   localparam int unsigned BURST_EFF = LOCK_EN ? BURST : 1;

   typedef enum logic {
      ST_IDLE,
      ST_OWN
   } state_e;

   state_e           state_q, state_d;
   logic [LW-1:0]    owner_q, owner_d;
   logic [LW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [LW-1:0]    scan_base;
   logic [LW-1:0]    cand;
   logic [LW-1:0]    sel_idx;
   logic             sel_found;
   logic             burst_last;
   logic             release_now;
   logic [7:0]       burst_cnt;
   logic [WIDTH-1:0] data_arr [NREQ];

`ifdef FIFO_ARB_LOCK_EN
   logic [7:0]       burst_cnt_q, burst_cnt_d;
   assign burst_cnt = burst_cnt_q;
`else
   assign burst_cnt = '0;
`endif

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign data_arr[gi] = data[gi*WIDTH +: WIDTH];
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
`ifdef FIFO_ARB_LOCK_EN
         burst_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
`ifdef FIFO_ARB_LOCK_EN
         burst_cnt_q <= burst_cnt_d;
`endif
      end
   end

   // Next-state logic; in OWN the scan starts just past the owner so a release
   // can hand over in the same cycle with the old owner at lowest priority.
   always_comb begin
      scan_base = (state_q == ST_OWN) ? owner_q + LW'(1) : rr_ptr_q;
      cand      = '0;
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = scan_base + LW'(k);
         if (!sel_found && req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end

      burst_last  = ({1'b0, burst_cnt} + 9'd1) == 9'(BURST_EFF);
      release_now = (state_q == ST_OWN) &&
                    (!req[owner_q] || (fifo_wr && burst_last));

      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (sel_found) begin
               state_d = ST_OWN;
               owner_d = sel_idx;
            end
         end
         ST_OWN: begin
            if (release_now) begin
               rr_ptr_d = owner_q + LW'(1);
               if (sel_found) begin
                  owner_d = sel_idx;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef FIFO_ARB_LOCK_EN
      burst_cnt_d = burst_cnt_q;
      if (state_q == ST_OWN) begin
         if (release_now) begin
            burst_cnt_d = '0;
         end else if (fifo_wr) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
         end
      end
`endif
   end

   // Outputs depend only on registered state plus req/full, so an async reset
   // kills any write in progress immediately.
   always_comb begin
      fifo_wr        = (state_q == ST_OWN) && req[owner_q] && !fifo_full;
      fifo_data      = fifo_wr ? data_arr[owner_q] : '0;
      gnt            = '0;
      gnt[owner_q]   = fifo_wr;
   end

   assign owner = owner_q;
   assign busy  = (state_q == ST_OWN);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter against a rule-level reference model.
module tb_fifo_wr_arbiter;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;
   localparam int BURST = 4;
   localparam int LW    = 2;
`ifdef FIFO_ARB_LOCK_EN
   localparam int BEFF  = BURST;
`else
   localparam int BEFF  = 1;
`endif
   localparam int VW    = NREQ + 1 + WIDTH + LW + 1;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] data;
   logic                  fifo_full;
   logic [NREQ-1:0]       gnt;
   logic                  fifo_wr;
   logic [WIDTH-1:0]      fifo_data;
   logic [LW-1:0]         owner;
   logic                  busy;

   int checks = 0;
   int errors = 0;

   // Reference model: ownership expressed as plain integers
   bit m_busy;
   int m_owner;
   int m_ptr;
   int m_cnt;

   fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .data      (data),
      .gnt       (gnt),
      .fifo_wr   (fifo_wr),
      .fifo_data (fifo_data),
      .fifo_full (fifo_full),
      .owner     (owner),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic int pick(int start);
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (start + k) % NREQ;
         if (req[i]) return i;
      end
      return -1;
   endfunction

   function automatic bit m_wr();
      return m_busy && req[m_owner] && !fifo_full;
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      logic [NREQ-1:0]  g;
      logic [WIDTH-1:0] d;
      g = '0;
      d = '0;
      if (m_wr()) begin
         g[m_owner] = 1'b1;
         d = data[m_owner*WIDTH +: WIDTH];
      end
      return {g, m_wr(), d, LW'(m_owner), m_busy};
   endfunction

   task automatic model_reset();
      m_busy  = 1'b0;
      m_owner = 0;
      m_ptr   = 0;
      m_cnt   = 0;
   endtask

   task automatic model_advance();
      bit wr, rel;
      int p;
      wr = m_wr();
      if (!m_busy) begin
         p = pick(m_ptr);
         if (p >= 0) begin
            m_busy  = 1'b1;
            m_owner = p;
            m_cnt   = 0;
         end
      end else begin
         rel = !req[m_owner] || (wr && (m_cnt + 1 == BEFF));
         if (wr) m_cnt++;
         if (rel) begin
            m_ptr = (m_owner + 1) % NREQ;
            p = pick(m_ptr);
            m_cnt = 0;
            if (p >= 0) m_owner = p;
            else m_busy = 1'b0;
         end
      end
   endtask

   task automatic tick();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req       = '0;
      data      = '0;
      fifo_full = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [VW-1:0] obs;
      rst_n     = 1'b0;
      req       = 4'b1111;
      data      = 32'h44332211;
      fifo_full = 1'b0;
      #3;
      obs = {gnt, fifo_wr, fifo_data, owner, busy};
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: observed %h expected %h", obs, {VW{1'b0}});
      end
      do_reset();
      @(negedge clk);
      obs = {gnt, fifo_wr, fifo_data, owner, busy};
      checks++;
      if (obs !== exp_vec()) begin
         errors++;
         $display("FAIL reset_idle: observed %h expected %h", obs, exp_vec());
      end
      tick();
   endtask

   task automatic test_single();
      logic [VW-1:0] obs;
      do_reset();
      req = 4'b0001;
      data[7:0] = 8'hA5;
      @(negedge clk);
      obs = {gnt, fifo_wr, fifo_data, owner, busy};
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL single_arb_cycle: observed %h expected %h", obs, {VW{1'b0}});
      end
      tick();
      @(negedge clk);
      obs = {gnt, fifo_wr, fifo_data, owner, busy};
      checks++;
      if (obs !== {4'b0001, 1'b1, 8'hA5, 2'd0, 1'b1}) begin
         errors++;
         $display("FAIL single_grant: observed %h expected %h", obs,
                  {4'b0001, 1'b1, 8'hA5, 2'd0, 1'b1});
      end
      tick();
      req = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         obs = {gnt, fifo_wr, fifo_data, owner, busy};
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL single_tail c%0d: observed %h expected %h", c, obs, exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_round_robin();
      logic [VW-1:0]    obs;
      logic [WIDTH-1:0] wlog [$];
      logic [WIDTH-1:0] want;
      do_reset();
      req  = 4'b1111;
      data = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int c = 0; c < 17; c++) begin
         @(negedge clk);
         obs = {gnt, fifo_wr, fifo_data, owner, busy};
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL rr_cycle c%0d: observed %h expected %h", c, obs, exp_vec());
         end
         if (fifo_wr) wlog.push_back(fifo_data);
         tick();
      end
      checks++;
      if (wlog.size() != 16) begin
         errors++;
         $display("FAIL rr_word_count: observed %0d expected 16", wlog.size());
      end
      for (int k = 0; k < wlog.size() && k < 16; k++) begin
         want = 8'(8'h10 + (k / BEFF) % NREQ);
         checks++;
         if (wlog[k] !== want) begin
            errors++;
            $display("FAIL rr_sequence w%0d: observed %h expected %h", k, wlog[k], want);
         end
      end
      req = '0;
      tick();
   endtask

   task automatic test_full_stall();
      logic [VW-1:0] obs;
      do_reset();
      req = 4'b0100;
      data[23:16] = 8'h12;
      @(negedge clk);
      obs = {gnt, fifo_wr, fifo_data, owner, busy};
      checks++;
      if (obs !== exp_vec()) begin
         errors++;
         $display("FAIL stall_arb: observed %h expected %h", obs, exp_vec());
      end
      tick();
      fifo_full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({gnt, fifo_wr, owner, busy} !== {4'b0000, 1'b0, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL stall_hold c%0d: observed gnt=%b wr=%b owner=%0d busy=%b expected gnt=0000 wr=0 owner=2 busy=1",
                     c, gnt, fifo_wr, owner, busy);
         end
         tick();
      end
      fifo_full = 1'b0;
      @(negedge clk);
      obs = {gnt, fifo_wr, fifo_data, owner, busy};
      checks++;
      if (obs !== {4'b0100, 1'b1, 8'h12, 2'd2, 1'b1}) begin
         errors++;
         $display("FAIL stall_release_write: observed %h expected %h", obs,
                  {4'b0100, 1'b1, 8'h12, 2'd2, 1'b1});
      end
      tick();
      req = '0;
      tick();
   endtask

   task automatic test_withdraw();
      logic [VW-1:0] obs;
      do_reset();
      req = 4'b1010;
      data[15:8]  = 8'h21;
      data[31:24] = 8'h23;
      @(negedge clk);
      obs = {gnt, fifo_wr, fifo_data, owner, busy};
      checks++;
      if (obs !== exp_vec()) begin
         errors++;
         $display("FAIL withdraw_arb: observed %h expected %h", obs, exp_vec());
      end
      tick();
      req = 4'b1000;
      @(negedge clk);
      obs = {gnt, fifo_wr, fifo_data, owner, busy};
      checks++;
      if (obs !== {4'b0000, 1'b0, 8'h00, 2'd1, 1'b1}) begin
         errors++;
         $display("FAIL withdraw_no_grant: observed %h expected %h", obs,
                  {4'b0000, 1'b0, 8'h00, 2'd1, 1'b1});
      end
      tick();
      @(negedge clk);
      obs = {gnt, fifo_wr, fifo_data, owner, busy};
      checks++;
      if (obs !== {4'b1000, 1'b1, 8'h23, 2'd3, 1'b1}) begin
         errors++;
         $display("FAIL withdraw_handoff: observed %h expected %h", obs,
                  {4'b1000, 1'b1, 8'h23, 2'd3, 1'b1});
      end
      tick();
      req = '0;
      tick();
   endtask

   task automatic test_async_reset();
      logic [VW-1:0] obs;
      do_reset();
      req = 4'b1000;
      data[31:24] = 8'h33;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         obs = {gnt, fifo_wr, fifo_data, owner, busy};
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL areset_pre c%0d: observed %h expected %h", c, obs, exp_vec());
         end
         if (c < 2) tick();
      end
      #2;
      rst_n = 1'b0;
      #1;
      obs = {gnt, fifo_wr, fifo_data, owner, busy};
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL areset_immediate: observed %h expected %h", obs, {VW{1'b0}});
      end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      obs = {gnt, fifo_wr, fifo_data, owner, busy};
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL areset_idle_cycle: observed %h expected %h", obs, {VW{1'b0}});
      end
      tick();
      @(negedge clk);
      obs = {gnt, fifo_wr, fifo_data, owner, busy};
      checks++;
      if (obs !== {4'b1000, 1'b1, 8'h33, 2'd3, 1'b1}) begin
         errors++;
         $display("FAIL areset_regrant: observed %h expected %h", obs,
                  {4'b1000, 1'b1, 8'h33, 2'd3, 1'b1});
      end
      tick();
      req = '0;
      tick();
   endtask

   task automatic test_random();
      logic [VW-1:0]   obs, ev;
      logic [NREQ-1:0] g;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         ev  = exp_vec();
         obs = {gnt, fifo_wr, fifo_data, owner, busy};
         checks++;
         if (obs !== ev) begin
            errors++;
            $display("FAIL random c%0d: observed %h expected %h req=%b full=%b",
                     c, obs, ev, req, fifo_full);
         end
         g = ev[VW-1 -: NREQ];
         tick();
         // Producers hold req/data until granted; rare early withdrawals.
         for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
               if (g[i]) begin
                  if ($urandom_range(0, 1) == 1) data[i*WIDTH +: WIDTH] = 8'($urandom);
                  else req[i] = 1'b0;
               end else if ($urandom_range(0, 49) == 0) begin
                  req[i] = 1'b0;
               end
            end else if ($urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
               data[i*WIDTH +: WIDTH] = 8'($urandom);
            end
         end
         fifo_full = ($urandom_range(0, 3) == 0);
      end
      req = '0;
      fifo_full = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_full_stall();
      test_withdraw();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
